// File: rtl/head_tracker_pkg.sv
// rtl/head_tracker_pkg.sv - state encoding, clog2 and axis vector pack/unpack helpers
package head_tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAN      = 3'd1,
        ST_WAIT_TICK = 3'd2,
        ST_CALC      = 3'd3,
        ST_APPLY     = 3'd4
    } state_t;

    // Widest packed axis vector the helpers accept
    localparam int VEC_MAX = 256;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Sign-extended field idx of width w from a packed vector
    function automatic logic signed [31:0] unpack_axis(input logic [VEC_MAX-1:0] vec,
                                                       input int idx, input int w);
        logic [VEC_MAX-1:0] sh;
        logic [31:0]        r;
        sh = vec >> (idx * w);
        for (int b = 0; b < 32; b++) begin
            r[b] = (b < w) ? sh[b] : sh[w-1];
        end
        return signed'(r);
    endfunction

    function automatic logic [VEC_MAX-1:0] pack_axis(input logic [VEC_MAX-1:0] vec,
                                                     input int idx, input int w,
                                                     input logic [31:0] val);
        logic [VEC_MAX-1:0] mask;
        mask = ((VEC_MAX'(1) << w) - VEC_MAX'(1)) << (idx * w);
        return (vec & ~mask) | ((VEC_MAX'(val) << (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/head_tracker_if.sv
// rtl/head_tracker_if.sv - frame/target/head bundle between generator, tracker and drivers
interface head_tracker_if #(
    parameter int W      = 11,
    parameter int N_AXES = 2
);
    logic                  frame_tick;
    logic [N_AXES*W-1:0]   target;
    logic [N_AXES*W-1:0]   head;
    logic [N_AXES*W-1:0]   step;
    logic                  busy;
    logic                  overrun;
    logic [2:0]            state;

    modport master (
        output frame_tick, target,
        input  head, step, busy, overrun, state
    );

    modport slave (
        input  frame_tick, target,
        output head, step, busy, overrun, state
    );
endinterface

// File: rtl/head_tracker_seq_divider.sv
// rtl/head_tracker_seq_divider.sv - signed restoring divider, truncating, WD+2 cycles start-to-done
module seq_divider
    import head_tracker_pkg::*;
#(
    parameter int WD = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [WD-1:0] dividend,
    input  logic signed [WD-1:0] divisor,
    output logic                 done,
    output logic signed [WD-1:0] quotient
);
    localparam int CNTW = clog2(WD + 1);

    logic [WD-1:0]   quo_q;
    logic [WD-1:0]   dvs_q;
    logic [WD-1:0]   rem_q;
    logic [CNTW-1:0] cnt_q;
    logic            run_q;
    logic            fin_q;
    logic            neg_q;
    logic            zero_q;
    logic [WD:0]     rem_sh;
    logic [WD:0]     diff;

    assign rem_sh = {rem_q, quo_q[WD-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            fin_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Magnitudes; the most negative value maps to its own bit pattern, which is correct unsigned
                quo_q  <= dividend[WD-1] ? -dividend : dividend;
                dvs_q  <= divisor[WD-1]  ? -divisor  : divisor;
                rem_q  <= '0;
                neg_q  <= dividend[WD-1] ^ divisor[WD-1];
                zero_q <= (divisor == '0);
                cnt_q  <= CNTW'(WD);
                run_q  <= 1'b1;
                fin_q  <= 1'b0;
            end else if (run_q) begin
                if (diff[WD]) begin
                    rem_q <= rem_sh[WD-1:0];
                    quo_q <= {quo_q[WD-2:0], 1'b0};
                end else begin
                    rem_q <= diff[WD-1:0];
                    quo_q <= {quo_q[WD-2:0], 1'b1};
                end
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    run_q <= 1'b0;
                    fin_q <= 1'b1;
                end
            end else if (fin_q) begin
                fin_q    <= 1'b0;
                done     <= 1'b1;
                quotient <= zero_q ? '0 : (neg_q ? -$signed(quo_q) : $signed(quo_q));
            end
        end
    end
endmodule

// File: rtl/head_tracker.sv
// rtl/head_tracker.sv - N-axis head tracker; HEAD_TRACKER_CLAMP_EN clamps latched targets to [LIMIT_MIN, LIMIT_MAX]
module head_tracker
    import head_tracker_pkg::*;
#(
    parameter int W             = 11,
    parameter int N_AXES        = 2,
    parameter int MAX_STEP      = 2,
    parameter int SETTLE_FRAMES = 60,
    parameter int LIMIT_MIN     = 0,
    parameter int LIMIT_MAX     = 639
) (
    input  logic          clk,
    input  logic          reset,
    head_tracker_if.slave bus
);
    localparam int WD        = W + 1;
    localparam int LOG2_STEP = clog2(MAX_STEP);
    localparam int CW        = (SETTLE_FRAMES < 2) ? 1 : clog2(SETTLE_FRAMES + 1);
    localparam int AW        = (N_AXES < 2) ? 1 : clog2(N_AXES);

    if (MAX_STEP < 1 || (MAX_STEP & (MAX_STEP - 1)) != 0 || LIMIT_MIN > LIMIT_MAX
        || N_AXES * W > VEC_MAX || SETTLE_FRAMES < 1) begin : g_bad_params
        $error("head_tracker: invalid parameters");
    end

    state_t                state_q, state_d;
    logic signed [W-1:0]   head_q  [N_AXES];
    logic signed [W-1:0]   step_q  [N_AXES];
    logic signed [W-1:0]   tgt_q   [N_AXES];
    logic signed [W-1:0]   tgt_lat [N_AXES];
    logic signed [WD-1:0]  rem_q   [N_AXES];
    logic signed [WD-1:0]  q_q     [N_AXES];
    logic signed [WD-1:0]  delta   [N_AXES];
    logic [WD-1:0]         mag     [N_AXES];
    logic [WD-1:0]         dmax;
    logic [WD:0]           frames_sum;
    logic [WD-1:0]         frames_plan;
    logic [WD-1:0]         frames_q;
    logic [CW-1:0]         settle_q;
    logic [AW-1:0]         axis_q;
    logic                  div_pending_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  settle_hit;
    logic                  div_start;
    logic                  div_done;
    logic signed [WD-1:0]  div_quot;
    logic [VEC_MAX-1:0]    head_vec;
    logic [VEC_MAX-1:0]    step_vec;

    function automatic logic signed [W-1:0] clamp_axis(input logic signed [W-1:0] v);
`ifdef HEAD_TRACKER_CLAMP_EN
        if (v < LIMIT_MIN) return W'(LIMIT_MIN);
        if (v > LIMIT_MAX) return W'(LIMIT_MAX);
`endif
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < N_AXES; i++) begin
            tgt_lat[i] = clamp_axis(W'(unpack_axis(VEC_MAX'(bus.target), i, W)));
        end
    end

    // Move plan: dominant-axis distance decides how many frames every axis gets
    always_comb begin
        dmax = '0;
        for (int i = 0; i < N_AXES; i++) begin
            delta[i] = WD'(tgt_q[i]) - WD'(head_q[i]);
            mag[i]   = delta[i][WD-1] ? -delta[i] : delta[i];
            if (mag[i] > dmax) dmax = mag[i];
        end
        frames_sum  = {1'b0, dmax} + (WD+1)'(MAX_STEP - 1);
        frames_plan = WD'(frames_sum >> LOG2_STEP);
    end

    assign settle_hit = (settle_q == CW'(SETTLE_FRAMES - 1));

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE:      if (bus.frame_tick && settle_hit) state_d = ST_PLAN;
            ST_PLAN:      state_d = (frames_plan == '0) ? ST_IDLE : ST_WAIT_TICK;
            ST_WAIT_TICK: if (bus.frame_tick) state_d = ST_CALC;
            ST_CALC: begin
                div_start = !div_pending_q;
                if (div_done && axis_q == AW'(N_AXES - 1)) state_d = ST_APPLY;
            end
            ST_APPLY:     state_d = (frames_q == WD'(1)) ? ST_IDLE : ST_WAIT_TICK;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            frames_q      <= '0;
            settle_q      <= '0;
            axis_q        <= '0;
            div_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < N_AXES; i++) begin
                head_q[i] <= '0;
                step_q[i] <= '0;
                tgt_q[i]  <= '0;
                rem_q[i]  <= '0;
                q_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (bus.frame_tick && state_q == ST_CALC) overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_tick) begin
                        if (settle_hit) begin
                            settle_q <= '0;
                            tgt_q    <= tgt_lat;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                end
                ST_PLAN: begin
                    rem_q    <= delta;
                    frames_q <= frames_plan;
                    if (frames_plan == '0) begin
                        for (int i = 0; i < N_AXES; i++) step_q[i] <= '0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                ST_WAIT_TICK: begin
                    if (bus.frame_tick) begin
                        axis_q        <= '0;
                        div_pending_q <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (div_start) div_pending_q <= 1'b1;
                    if (div_done) begin
                        q_q[axis_q]   <= div_quot;
                        div_pending_q <= 1'b0;
                        if (axis_q != AW'(N_AXES - 1)) axis_q <= axis_q + 1'b1;
                    end
                end
                ST_APPLY: begin
                    for (int i = 0; i < N_AXES; i++) begin
                        head_q[i] <= head_q[i] + W'(q_q[i]);
                        rem_q[i]  <= rem_q[i] - q_q[i];
                        step_q[i] <= W'(q_q[i]);
                    end
                    frames_q <= frames_q - 1'b1;
                    if (frames_q == WD'(1)) busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    seq_divider #(.WD(WD)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (rem_q[axis_q]),
        .divisor  ($signed(frames_q)),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        head_vec = '0;
        step_vec = '0;
        for (int i = 0; i < N_AXES; i++) begin
            head_vec = pack_axis(head_vec, i, W, 32'(head_q[i]));
            step_vec = pack_axis(step_vec, i, W, 32'(step_q[i]));
        end
    end

    assign bus.head    = (N_AXES*W)'(head_vec);
    assign bus.step    = (N_AXES*W)'(step_vec);
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_head_tracker.sv
// tb/tb_head_tracker.sv - randomized self-checking bench for head_tracker against a frame-level model
module tb_head_tracker;
    localparam int W        = 11;
    localparam int N_AXES   = 2;
    localparam int MAX_STEP = 2;
    localparam int SETTLE   = 4;

    logic clk;
    logic reset;
    int   tick_period;
    int   tick_cnt;
    int   n_tests;
    int   n_fail;
    int   mh [2];

    head_tracker_if #(.W(W), .N_AXES(N_AXES)) bus ();

    head_tracker #(
        .W(W), .N_AXES(N_AXES), .MAX_STEP(MAX_STEP), .SETTLE_FRAMES(SETTLE),
        .LIMIT_MIN(0), .LIMIT_MAX(639)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        bus.frame_tick = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            if (tick_cnt >= tick_period) begin
                tick_cnt = 0;
                bus.frame_tick = 1'b1;
            end else begin
                bus.frame_tick = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int head_ax(input int a);
        logic [2*W-1:0] v;
        logic [W-1:0]   f;
        v = bus.head;
        f = v[a*W +: W];
        return int'($signed(f));
    endfunction

    function automatic int step_ax(input int a);
        logic [2*W-1:0] v;
        logic [W-1:0]   f;
        v = bus.step;
        f = v[a*W +: W];
        return int'($signed(f));
    endfunction

    function automatic int clamp_t(input int v);
`ifdef HEAD_TRACKER_CLAMP_EN
        if (v < 0)   return 0;
        if (v > 639) return 639;
`endif
        return v;
    endfunction

    task automatic wait_apply(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.state == 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_head_x"}, head_ax(0), 0);
        check({tag, "_head_y"}, head_ax(1), 0);
        check({tag, "_step_x"}, step_ax(0), 0);
        check({tag, "_step_y"}, step_ax(1), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
        check({tag, "_state"}, int'(bus.state), 0);
    endtask

    // Frame-level model: ceil(dominant/MAX_STEP) frames, each axis gets remaining/frames_left
    task automatic do_move(input int tx, input int ty, input int max_frames);
        int  et [2];
        int  rem [2];
        int  dm, f, q, ad;
        bit  ok, busy_seen, plan_seen;
        logic [W-1:0] fx, fy;
        fx = W'(tx);
        fy = W'(ty);
        bus.target = {fy, fx};
        et[0] = clamp_t(tx);
        et[1] = clamp_t(ty);
        dm = 0;
        for (int a = 0; a < 2; a++) begin
            rem[a] = et[a] - mh[a];
            ad = (rem[a] < 0) ? -rem[a] : rem[a];
            if (ad > dm) dm = ad;
        end
        f = (dm + MAX_STEP - 1) / MAX_STEP;
        if (f == 0) begin
            busy_seen = 1'b0;
            plan_seen = 1'b0;
            for (int c = 0; c < (SETTLE + 2) * tick_period; c++) begin
                @(negedge clk);
                if (bus.busy) busy_seen = 1'b1;
                if (bus.state == 3'd1) plan_seen = 1'b1;
            end
            check("nomove_plan_seen", int'(plan_seen), 1);
            check("nomove_busy", int'(busy_seen), 0);
            check("nomove_step_x", step_ax(0), 0);
            check("nomove_step_y", step_ax(1), 0);
            check("nomove_state", int'(bus.state), 0);
            check("nomove_head_x", head_ax(0), mh[0]);
            return;
        end
        for (int k = f; k > 0 && (f - k) < max_frames; k--) begin
            wait_apply(ok);
            if (!ok) begin
                check("apply_timeout", 0, 1);
                return;
            end
            for (int a = 0; a < 2; a++) begin
                q = rem[a] / k;
                rem[a] -= q;
                mh[a] += q;
                check(a == 0 ? "step_x" : "step_y", step_ax(a), q);
                check(a == 0 ? "head_x" : "head_y", head_ax(a), mh[a]);
            end
            check("busy", int'(bus.busy), (k > 1) ? 1 : 0);
        end
    endtask

    initial begin
        int rx, ry;
        bit ok;
        n_tests     = 0;
        n_fail      = 0;
        tick_period = 64;
        mh[0] = 0;
        mh[1] = 0;
        bus.target = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        do_move(100, 50, 1 << 20);
        check("move1_final_x", head_ax(0), clamp_t(100));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mh[0] = 0;
        mh[1] = 0;
        check_reset_values("reset2");
        do_move(-7, 3, 1 << 20);
        do_move(-7, 3, 1 << 20);

        for (int n = 0; n < 6; n++) begin
            rx = mh[0] + int'($urandom_range(0, 40)) - 20;
            ry = mh[1] + int'($urandom_range(0, 40)) - 20;
            do_move(rx, ry, 1 << 20);
        end

        check("overrun_before", int'(bus.overrun), 0);
        tick_period = 2;
        do_move(300, 200, 1 << 20);
        check("overrun_set", int'(bus.overrun), 1);
        tick_period = 64;
        do_move(mh[0] - 9, mh[1] + 5, 1 << 20);
        check("overrun_sticky", int'(bus.overrun), 1);

        do_move(100, 50, 10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mh[0] = 0;
        mh[1] = 0;
        check_reset_values("midreset");

        do_move(1000, -20, 1 << 20);
`ifdef HEAD_TRACKER_CLAMP_EN
        check("far_final_x", head_ax(0), 639);
        check("far_final_y", head_ax(1), 0);
`else
        check("far_final_x", head_ax(0), 1000);
        check("far_final_y", head_ax(1), -20);
`endif
        check("far_busy", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
